// File: rtl/alu_iter_exec_pkg.sv
// Shared opcode and modifier encodings for the iterative ALU execution unit.
// The one-bit modifier selects signed/unsigned for SLT and logical/arithmetic for SR.
package alu_iter_exec_pkg;

    localparam logic [2:0] ALU_OP_ADD      = 3'b000;
    localparam logic [2:0] ALU_OP_SUB      = 3'b001;
    localparam logic [2:0] ALU_OP_SLL      = 3'b010;
    localparam logic [2:0] ALU_OP_SLT_BASE = 3'b011;
    localparam logic [2:0] ALU_OP_XOR      = 3'b100;
    localparam logic [2:0] ALU_OP_SR_BASE  = 3'b101;
    localparam logic [2:0] ALU_OP_OR       = 3'b110;
    localparam logic [2:0] ALU_OP_AND      = 3'b111;

    localparam logic ALU_SELECT_UNSIGNED = 1'b1;
    localparam logic ALU_SELECT_ARITH    = 1'b1;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SR_BASE);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit left/right shifter; the caller chooses the bit shifted in
// (zero for SLL/SRL, the latched sign for SRA).
module alu_shift_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic            right,
    input  logic            fill,
    output logic [XLEN-1:0] shifted
);

    always_comb begin
        if (right) begin
            shifted = {fill, data[XLEN-1:1]};
        end else begin
            shifted = {data[XLEN-2:0], fill};
        end
    end

endmodule

// File: rtl/alu_iter_exec.sv
// Multi-cycle ALU execution unit: single-cycle logic/arithmetic ops, shifts
// iterated one bit per cycle, result returned over a valid/ready handshake.
module alu_iter_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      ALUControl_i,
    input  logic            ALUModifier_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);
    import alu_iter_exec_pkg::*;

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] work_reg, work_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [SHW-1:0]  count_reg, count_next;
    logic            dir_reg, dir_next;
    logic            fill_reg, fill_next;

    logic [SHW-1:0]  shamt;
    logic            cmd_shift, cmd_dir, cmd_fill, accept;
    logic            lt_signed, lt_unsigned, lt_sel;
    logic [XLEN-1:0] alu_comb;
    logic [XLEN-1:0] step_in, step_out;
    logic            step_dir, step_fill;

    // Decode of the command currently presented on the inputs.
    always_comb begin
        shamt       = src_b_i[SHW-1:0];
        cmd_shift   = is_shift_op(ALUControl_i);
        cmd_dir     = (ALUControl_i == ALU_OP_SR_BASE);
        cmd_fill    = cmd_dir && (ALUModifier_i == ALU_SELECT_ARITH) && src_a_i[XLEN-1];
        lt_signed   = $signed(src_a_i) < $signed(src_b_i);
        lt_unsigned = src_a_i < src_b_i;
        lt_sel      = (ALUModifier_i == ALU_SELECT_UNSIGNED) ? lt_unsigned : lt_signed;
    end

    // Shift ops here only cover the zero-count case, which passes A through.
    always_comb begin
        case (ALUControl_i)
            ALU_OP_ADD:      alu_comb = src_a_i + src_b_i;
            ALU_OP_SUB:      alu_comb = src_a_i - src_b_i;
            ALU_OP_SLL:      alu_comb = src_a_i;
            ALU_OP_SLT_BASE: alu_comb = {{(XLEN-1){1'b0}}, lt_sel};
            ALU_OP_XOR:      alu_comb = src_a_i ^ src_b_i;
            ALU_OP_SR_BASE:  alu_comb = src_a_i;
            ALU_OP_OR:       alu_comb = src_a_i | src_b_i;
            ALU_OP_AND:      alu_comb = src_a_i & src_b_i;
            default:         alu_comb = src_a_i;
        endcase
    end

    // The first bit step happens on the accept edge itself, so a count-N
    // shift reaches DONE after exactly N edges.
    always_comb begin
        if (state_reg == S_IDLE) begin
            step_in   = src_a_i;
            step_dir  = cmd_dir;
            step_fill = cmd_fill;
        end else begin
            step_in   = work_reg;
            step_dir  = dir_reg;
            step_fill = fill_reg;
        end
    end

    alu_shift_step #(
        .XLEN(XLEN)
    ) u_shift_step (
        .data   (step_in),
        .right  (step_dir),
        .fill   (step_fill),
        .shifted(step_out)
    );

    always_comb begin
        state_next  = state_reg;
        work_next   = work_reg;
        result_next = result_reg;
        count_next  = count_reg;
        dir_next    = dir_reg;
        fill_next   = fill_reg;
        ready_o     = (state_reg == S_IDLE);
        valid_o     = (state_reg == S_DONE);
        accept      = valid_i && ready_o;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    dir_next  = cmd_dir;
                    fill_next = cmd_fill;
                    if (cmd_shift && (shamt > SHW'(1))) begin
                        state_next = S_SHIFT;
                        work_next  = step_out;
                        count_next = shamt - SHW'(1);
                    end else if (cmd_shift && (shamt == SHW'(1))) begin
                        state_next  = S_DONE;
                        result_next = step_out;
                    end else begin
                        state_next  = S_DONE;
                        result_next = alu_comb;
                    end
                end
            end
            S_SHIFT: begin
                if (count_reg == SHW'(1)) begin
                    state_next  = S_DONE;
                    result_next = step_out;
                    count_next  = '0;
                end else begin
                    work_next  = step_out;
                    count_next = count_reg - SHW'(1);
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= S_IDLE;
            work_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            dir_reg    <= 1'b0;
            fill_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            work_reg   <= work_next;
            result_reg <= result_next;
            count_reg  <= count_next;
            dir_reg    <= dir_next;
            fill_reg   <= fill_next;
        end
    end

    assign result_o = result_reg;
    assign zero_o   = (result_reg == '0);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed table-driven bench for alu_iter_exec, plus hand sequences for
// backpressure and reset in the middle of a shift.
module tb_alu_iter_exec;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  alu_ctrl;
    logic        alu_mod;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result;
    logic        zero;

    int checks;
    int failures;

    alu_iter_exec #(
        .XLEN(32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ALUControl_i (alu_ctrl),
        .ALUModifier_i(alu_mod),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result),
        .zero_o       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic md, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] res, output logic zr,
                           output int lat, output logic busy_ok);
        @(negedge clk);
        check("ready_before_accept", {31'b0, ready_o}, 32'd1);
        alu_ctrl = op;
        alu_mod  = md;
        src_a    = a;
        src_b    = b;
        valid_i  = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!valid_o && lat < 200) begin
            if (ready_o) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        zr  = zero;
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("ready_after_handshake", {31'b0, ready_o}, 32'd1);
        check("valid_after_handshake", {31'b0, valid_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic        zr;
        int          lat;
        logic        busy_ok;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{3'b001, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
        vecs[1]  = '{3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[2]  = '{3'b011, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
        vecs[3]  = '{3'b011, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
        vecs[4]  = '{3'b101, 1'b1, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4};
        vecs[5]  = '{3'b101, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4};
        vecs[6]  = '{3'b010, 1'b0, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1};
        vecs[7]  = '{3'b010, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 31};
        vecs[8]  = '{3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1};
        vecs[9]  = '{3'b110, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1};
        vecs[10] = '{3'b111, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1};
        vecs[11] = '{3'b101, 1'b1, 32'h7000_0000, 32'h0000_0001, 32'h3800_0000, 1};
        vecs[12] = '{3'b010, 1'b0, 32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1};
        vecs[13] = '{3'b101, 1'b1, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 31};
        vecs[14] = '{3'b001, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};
        vecs[15] = '{3'b011, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1};

        rst_n    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        alu_ctrl = 3'b000;
        alu_mod  = 1'b0;
        src_a    = 32'h0;
        src_b    = 32'h0;
        #1;
        check("reset_result", result, 32'h0);
        check("reset_zero", {31'b0, zero}, 32'd1);
        check("reset_valid", {31'b0, valid_o}, 32'd0);
        check("reset_ready", {31'b0, ready_o}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i].op, vecs[i].md, vecs[i].a, vecs[i].b, res, zr, lat, busy_ok);
            $display("txn %0d op=%0d mod=%0d a=%h b=%h result=%h zero=%0d latency=%0d",
                     i, vecs[i].op, vecs[i].md, vecs[i].a, vecs[i].b, res, zr, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_zero", i), {31'b0, zr}, {31'b0, (vecs[i].exp == 32'h0)});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy", i), {31'b0, busy_ok}, 32'd1);
        end

        // Backpressure: result held while new commands are offered and ignored.
        @(negedge clk);
        alu_ctrl = 3'b001;
        alu_mod  = 1'b0;
        src_a    = 32'd7;
        src_b    = 32'd3;
        valid_i  = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("bp_valid_first", {31'b0, valid_o}, 32'd1);
        check("bp_result_first", result, 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            alu_ctrl = 3'b000;
            src_a    = 32'd1;
            src_b    = 32'd1;
            valid_i  = 1'b1;
            @(posedge clk);
            #1;
            $display("txn bp_hold cycle=%0d result=%h valid=%0d ready=%0d", c, result, valid_o, ready_o);
            check("bp_hold_result", result, 32'd4);
            check("bp_hold_valid", {31'b0, valid_o}, 32'd1);
            check("bp_hold_ready", {31'b0, ready_o}, 32'd0);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("bp_release_ready", {31'b0, ready_o}, 32'd1);
        check("bp_release_valid", {31'b0, valid_o}, 32'd0);
        check("bp_release_result", result, 32'd4);
        @(posedge clk);
        #1;
        check("bp_not_queued", {31'b0, valid_o}, 32'd0);

        // Reset in the middle of a 20-bit shift.
        @(negedge clk);
        alu_ctrl = 3'b010;
        alu_mod  = 1'b0;
        src_a    = 32'h1;
        src_b    = 32'd20;
        valid_i  = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("mid_shift_busy", {31'b0, ready_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        $display("txn mid_shift_reset result=%h valid=%0d ready=%0d zero=%0d", result, valid_o, ready_o, zero);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_valid", {31'b0, valid_o}, 32'd0);
        check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        check("rst_mid_zero", {31'b0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_valid", {31'b0, valid_o}, 32'd0);
        run_cmd(3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, res, zr, lat, busy_ok);
        $display("txn post_reset_xor result=%h zero=%0d latency=%0d", res, zr, lat);
        check("post_reset_xor_result", res, 32'h0000_FF00);
        check("post_reset_xor_latency", lat, 1);
        check("post_reset_xor_zero", {31'b0, zr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
